// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: shares RW port 0 of a single-port SRAM macro between two
// requesters with round-robin arbitration, a 3-cycle read pipeline and an
// optional post-reset zero sweep of the whole array.
module sram_port0_arbiter #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_WMASKS     = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_q, clr_d;
    logic                    ptr_q, ptr_d;
    logic                    run;
    logic                    gnt_a, gnt_b, accept;
    logic                    sel_we;
    logic [NUM_WMASKS-1:0]   sel_wmask;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    logic                    csb_q, web_q;
    logic [NUM_WMASKS-1:0]   wmask_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   din_q;
    logic                    p1_vld_q, p1_id_q, p2_vld_q, p2_id_q;
    logic                    rvalid_q, rid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    // Grant logic: lone requester always wins, contention goes to the pointer side
    always_comb begin
        run       = (state_q == ST_RUN) && !wb_rst_i;
        gnt_a     = run && a_valid && (!b_valid || !ptr_q);
        gnt_b     = run && b_valid && (!a_valid || ptr_q);
        accept    = gnt_a || gnt_b;
        sel_we    = gnt_b ? b_we    : a_we;
        sel_wmask = gnt_b ? b_wmask : a_wmask;
        sel_addr  = gnt_b ? b_addr  : a_addr;
        sel_wdata = gnt_b ? b_wdata : a_wdata;
    end

    // Next state for the INIT/RUN FSM, sweep counter and round-robin pointer
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            clr_d = clr_q + 1'b1;
            if (clr_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
        if (gnt_a) begin
            ptr_d = 1'b1;
        end else if (gnt_b) begin
            ptr_d = 1'b0;
        end
    end

    // Control registers: reset picks the sweep or goes straight to RUN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
            clr_q   <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            ptr_q   <= ptr_d;
        end
    end

    // Macro pin registers: sweep write, accepted request, or idle with address/data held
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else if (state_q == ST_INIT) begin
            csb_q   <= 1'b0;
            web_q   <= 1'b0;
            wmask_q <= '1;
            addr_q  <= clr_q;
            din_q   <= '0;
        end else if (accept) begin
            csb_q   <= 1'b0;
            web_q   <= ~sel_we;
            wmask_q <= sel_wmask;
            addr_q  <= sel_addr;
            din_q   <= sel_wdata;
        end else begin
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
        end
    end

    // Read pipeline: requester id rides two stages, then macro output is captured
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            p1_vld_q <= 1'b0;
            p1_id_q  <= 1'b0;
            p2_vld_q <= 1'b0;
            p2_id_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rid_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            p1_vld_q <= accept && !sel_we;
            p1_id_q  <= gnt_b;
            p2_vld_q <= p1_vld_q;
            p2_id_q  <= p1_id_q;
            rvalid_q <= p2_vld_q;
            rid_q    <= p2_id_q;
            if (p2_vld_q) begin
                rdata_q <= sram_dout0;
            end
        end
    end

    assign a_ready     = gnt_a;
    assign b_ready     = gnt_b;
    assign init_done   = (state_q == ST_RUN) && !wb_rst_i;
    assign a_rvalid    = rvalid_q && !rid_q;
    assign b_rvalid    = rvalid_q && rid_q;
    assign a_rdata     = rdata_q;
    assign b_rdata     = rdata_q;
    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_wmask0 = wmask_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Testbench for sram_port0_arbiter: behavioural SRAM macro, reference memory
// and a queue of expected read responses checked against the DUT outputs.
module tb_sram_port0_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aValid = 1'b0, aWe = 1'b0, bValid = 1'b0, bWe = 1'b0;
    logic [3:0]  aWmask = '0, bWmask = '0;
    logic [8:0]  aAddr = '0, bAddr = '0;
    logic [31:0] aWdata = '0, bWdata = '0;
    logic        aReady, bReady, aRvalid, bRvalid, initDone;
    logic [31:0] aRdata, bRdata;
    logic        sramCsb0, sramWeb0;
    logic [3:0]  sramWmask0;
    logic [8:0]  sramAddr0;
    logic [31:0] sramDin0;
    logic [31:0] sramDout0 = '0;

    logic        aReady0, bReady0, aRvalid0, bRvalid0, initDone0;
    logic        csb0Nc, web0Nc;
    logic [3:0]  wmask0Nc;
    logic [8:0]  addr0Nc;
    logic [31:0] din0Nc, aRdata0, bRdata0;

    int checksRun = 0;
    int checksPassed = 0;
    int cyc = 0;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] refMem [0:511];
    logic [31:0] sramMem [0:511];
    bit          memInitDone = 1'b0;
    logic        capV = 1'b0, capW = 1'b0;
    logic [8:0]  capAddr = '0;
    logic [31:0] capDin = '0;
    logic [3:0]  capMask = '0;

    sram_port0_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .a_valid(aValid), .a_ready(aReady), .a_we(aWe), .a_wmask(aWmask),
        .a_addr(aAddr), .a_wdata(aWdata), .a_rvalid(aRvalid), .a_rdata(aRdata),
        .b_valid(bValid), .b_ready(bReady), .b_we(bWe), .b_wmask(bWmask),
        .b_addr(bAddr), .b_wdata(bWdata), .b_rvalid(bRvalid), .b_rdata(bRdata),
        .init_done(initDone),
        .sram_csb0(sramCsb0), .sram_web0(sramWeb0), .sram_wmask0(sramWmask0),
        .sram_addr0(sramAddr0), .sram_din0(sramDin0), .sram_dout0(sramDout0)
    );

    sram_port0_arbiter #(.CLEAR_ON_RESET(1'b0)) dutNoClear (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .a_valid(1'b1), .a_ready(aReady0), .a_we(1'b0), .a_wmask(4'hF),
        .a_addr(9'h000), .a_wdata(32'h0), .a_rvalid(aRvalid0), .a_rdata(aRdata0),
        .b_valid(1'b0), .b_ready(bReady0), .b_we(1'b0), .b_wmask(4'h0),
        .b_addr(9'h000), .b_wdata(32'h0), .b_rvalid(bRvalid0), .b_rdata(bRdata0),
        .init_done(initDone0),
        .sram_csb0(csb0Nc), .sram_web0(web0Nc), .sram_wmask0(wmask0Nc),
        .sram_addr0(addr0Nc), .sram_din0(din0Nc), .sram_dout0(32'h0)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Macro model: capture pins on the rising edge
    always @(posedge clk) begin
        capV    <= !sramCsb0;
        capW    <= !sramWeb0;
        capAddr <= sramAddr0;
        capDin  <= sramDin0;
        capMask <= sramWmask0;
    end

    // Macro model: perform the captured access on the falling edge, array starts as garbage
    always @(negedge clk) begin
        if (!memInitDone) begin
            for (int i = 0; i < 512; i++) sramMem[i] = $urandom;
            memInitDone = 1'b1;
        end
        if (capV) begin
            if (capW) begin
                for (int i = 0; i < 4; i++)
                    if (capMask[i]) sramMem[capAddr][8*i +: 8] = capDin[8*i +: 8];
            end else begin
                sramDout0 <= sramMem[capAddr];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checksRun++;
        if (got === exp) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, got, exp, cyc);
    endtask

    // Scoreboard: pop and compare responses, record accepted requests in program order
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
            for (int i = 0; i < 512; i++) refMem[i] = '0;
        end else begin
            if (aRvalid || bRvalid) begin
                checkOutput("rvBoth", 32'(aRvalid & bRvalid), 32'd0);
                if (sbq.size() == 0) begin
                    checkOutput("rvUnexp", 32'(sbq.size()), 32'd1);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("rid", 32'(bRvalid), 32'(e.id));
                    checkOutput("rdata", bRvalid ? bRdata : aRdata, e.data);
                    checkOutput("rlat", 32'(cyc - e.cyc), 32'd3);
                end
            end
            for (int s = 0; s < 2; s++) begin
                logic        v, we;
                logic [3:0]  m;
                logic [8:0]  ad;
                logic [31:0] wd;
                v  = s ? (bValid && bReady) : (aValid && aReady);
                we = s ? bWe : aWe;
                m  = s ? bWmask : aWmask;
                ad = s ? bAddr : aAddr;
                wd = s ? bWdata : aWdata;
                if (v) begin
                    if (we) begin
                        for (int i = 0; i < 4; i++)
                            if (m[i]) refMem[ad][8*i +: 8] = wd[8*i +: 8];
                    end else begin
                        e.id   = (s != 0);
                        e.data = refMem[ad];
                        e.cyc  = cyc;
                        sbq.push_back(e);
                    end
                end
            end
        end
    end

    // Drive one request from the current cycle until it is granted, then drop valid
    task automatic applyStimulus(input bit side, input bit we, input logic [3:0] mask,
                                 input logic [8:0] addr, input logic [31:0] data);
        bit ok = 1'b0;
        if (side) begin
            bValid = 1'b1; bWe = we; bWmask = mask; bAddr = addr; bWdata = data;
        end else begin
            aValid = 1'b1; aWe = we; aWmask = mask; aAddr = addr; aWdata = data;
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (side ? bReady : aReady) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) checkOutput("grantTimeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        if (side) bValid = 1'b0; else aValid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 20; t++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain", 32'(sbq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Follow the zero sweep from the first cycle after reset release to the first RUN cycle
    task automatic runSweepCheck();
        int good = 0;
        int doneErr = 0;
        for (int k = 1; k <= 513; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checkOutput("rstCsb", 32'(sramCsb0), 32'd1);
                checkOutput("noClrDone", 32'(initDone0), 32'd1);
                checkOutput("noClrReady", 32'(aReady0), 32'd1);
            end
            if (k >= 2 && !sramCsb0 && !sramWeb0 && sramAddr0 == 9'(k - 2) &&
                sramDin0 == 32'h0 && sramWmask0 == 4'hF) good++;
            if (initDone != (k == 513)) doneErr++;
        end
        checkOutput("sweepWrites", 32'(good), 32'd512);
        checkOutput("initDoneTiming", 32'(doneErr), 32'd0);
        @(posedge clk); #1;
    endtask

    // Safety net against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence: reset, sweep, RAW, masks, arbitration, reset mid-flight
    initial begin
        rst = 1'b1;
        aValid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstCsbHi", 32'(sramCsb0), 32'd1);
        checkOutput("rstWebHi", 32'(sramWeb0), 32'd1);
        checkOutput("rstAddr", 32'(sramAddr0), 32'd0);
        checkOutput("rstReady", 32'(aReady), 32'd0);
        checkOutput("rstDone", 32'(initDone), 32'd0);
        checkOutput("rstRvalid", 32'(aRvalid | bRvalid), 32'd0);
        checkOutput("rstRdata", aRdata, 32'd0);
        checkOutput("rstNoClrDone", 32'(initDone0), 32'd0);
        checkOutput("rstNoClrReady", 32'(aReady0), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        aValid = 1'b0;
        runSweepCheck();

        applyStimulus(0, 0, 4'hF, 9'h0AB, 32'h0);
        applyStimulus(0, 1, 4'hF, 9'h005, 32'hDEADBEEF);
        applyStimulus(0, 0, 4'hF, 9'h005, 32'h0);
        applyStimulus(0, 1, 4'h0, 9'h005, 32'h12345678);
        applyStimulus(0, 0, 4'hF, 9'h005, 32'h0);
        waitDrain();
        checkOutput("idleCsb", 32'(sramCsb0), 32'd1);
        checkOutput("idleWeb", 32'(sramWeb0), 32'd1);
        checkOutput("holdAddr", 32'(sramAddr0), 32'h005);

        applyStimulus(1, 1, 4'b0101, 9'h1FF, 32'h11223344);
        applyStimulus(1, 0, 4'hF, 9'h1FF, 32'h0);
        waitDrain();
        checkOutput("maskRef", refMem[9'h1FF], 32'h00220044);

        aValid = 1'b1; aWe = 1'b0; aAddr = 9'h005;
        bValid = 1'b1; bWe = 1'b0; bAddr = 9'h1FF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("gntA", 32'(aReady), 32'(i % 2 == 0));
            checkOutput("gntB", 32'(bReady), 32'(i % 2 == 1));
            @(posedge clk); #1;
        end
        aValid = 1'b0;
        bValid = 1'b0;
        waitDrain();

        applyStimulus(0, 0, 4'hF, 9'h005, 32'h0);
        applyStimulus(1, 0, 4'hF, 9'h1FF, 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rstDropRv", 32'(aRvalid | bRvalid), 32'd0);
            if (i >= 1) checkOutput("rstDropCsb", 32'(sramCsb0), 32'd1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        runSweepCheck();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("postRstRv", 32'(aRvalid | bRvalid), 32'd0);
        end
        @(posedge clk); #1;
        applyStimulus(0, 0, 4'hF, 9'h005, 32'h0);
        waitDrain();

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
